// File: rtl/simple_ctrl.sv
// -----------------------------------------------------------------------------
// simple_ctrl
//
// Multi-cycle control unit for a small accumulator datapath (4-entry register
// file, accumulator A, 3-bit-opcode ALU). It fetches 16-bit instructions over
// a req/valid handshake, holds them in an internal instruction register (IR)
// and walks each one through a fixed state sequence, generating the datapath
// strobes and owning the program counter.
//
// Instruction format: op = [15:12], rd = [11:10], rs = [9:8], imm = [7:0]
//   0ooo  ALU      rd <= A ooo RF[rd], with A loaded from RF[rs] first
//   1000  LDI      rd <= imm
//   1001  JMP      pc <= imm
//   1010  BZ       pc <= Z ? imm : pc+1
//   1111  HALT     stop until reset
//   other NOP      pc <= pc+1
//
// State sequences (FETCH accepts the word on the cycle instr_valid is high):
//   ALU : FETCH -> DECODE -> LOAD_A -> EXEC -> WB -> FETCH
//   LDI : FETCH -> DECODE -> WB -> FETCH
//   JMP / BZ / NOP : FETCH -> DECODE -> FETCH
//   HALT: FETCH -> DECODE -> HALT (absorbing)
//
// Ports:
//   clk              in   system clock, all state on rising edge
//   rst              in   asynchronous, active-low reset
//   instr_in         in   instruction word from instruction memory
//   instr_valid      in   instr_in valid this cycle (only honoured in FETCH)
//   alu_zero         in   ALU result-zero flag, captured into Z in EXEC
//   instr_req        out  instruction fetch request (FETCH, out of reset)
//   pc               out  current instruction address
//   RF_addr          out  register file address
//   RF_we            out  register file write enable (WB)
//   RF_wsel          out  RF write source: 0 = ALU result, 1 = imm_out
//   imm_out          out  immediate field of IR (zero-extended by datapath)
//   A_we             out  accumulator load enable (LOAD_A)
//   ALU_ce           out  ALU clock enable (EXEC)
//   ALU_opcode_wire  out  ALU operation (EXEC, held through WB)
//   halted           out  controller stopped in HALT
//
// All outputs are decoded from the state register and IR only; instr_in never
// reaches an output except through IR. At most one of A_we / ALU_ce / RF_we is
// high in any cycle because each belongs to exactly one state.
// -----------------------------------------------------------------------------
module simple_ctrl #(
    parameter int unsigned       PC_W     = 8,
    parameter logic [PC_W-1:0]   RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     instr_in,
    input  logic            instr_valid,
    input  logic            alu_zero,
    output logic            instr_req,
    output logic [PC_W-1:0] pc,
    output logic [1:0]      RF_addr,
    output logic            RF_we,
    output logic            RF_wsel,
    output logic [7:0]      imm_out,
    output logic            A_we,
    output logic            ALU_ce,
    output logic [2:0]      ALU_opcode_wire,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_LOAD_A = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'b1000;
    localparam logic [3:0] OP_JMP  = 4'b1001;
    localparam logic [3:0] OP_BZ   = 4'b1010;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q,    pc_d;
    logic [15:0]     ir_q,    ir_d;
    logic            z_q,     z_d;

    // -------------------------------------------------------------------------
    // IR field decode
    // -------------------------------------------------------------------------
    logic [3:0]      op;
    logic [1:0]      rd;
    logic [1:0]      rs;
    logic [7:0]      imm;
    logic            is_alu;
    logic            is_ldi;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_imm;

    assign op     = ir_q[15:12];
    assign rd     = ir_q[11:10];
    assign rs     = ir_q[9:8];
    assign imm    = ir_q[7:0];
    assign is_alu = ~op[3];
    assign is_ldi = (op == OP_LDI);

    // Natural wrap modulo 2^PC_W: all-ones + 1 gives 0 with no carry kept.
    assign pc_inc = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    // Jump target is the immediate resized to the PC width.
    assign pc_imm = PC_W'(imm);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        z_d     = z_q;

        unique case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr_in;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                if (is_alu) begin
                    state_d = S_LOAD_A;
                end else begin
                    unique case (op)
                        OP_LDI: begin
                            state_d = S_WB;
                        end
                        OP_JMP: begin
                            pc_d    = pc_imm;
                            state_d = S_FETCH;
                        end
                        OP_BZ: begin
                            pc_d    = z_q ? pc_imm : pc_inc;
                            state_d = S_FETCH;
                        end
                        OP_HALT: begin
                            state_d = S_HALT;
                        end
                        default: begin
                            pc_d    = pc_inc;
                            state_d = S_FETCH;
                        end
                    endcase
                end
            end

            S_LOAD_A: begin
                state_d = S_EXEC;
            end

            S_EXEC: begin
                z_d     = alu_zero;
                state_d = S_WB;
            end

            S_WB: begin
                pc_d    = pc_inc;
                state_d = S_FETCH;
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode (state and IR only)
    // -------------------------------------------------------------------------
    always_comb begin
        instr_req       = 1'b0;
        RF_addr         = rd;
        RF_we           = 1'b0;
        RF_wsel         = 1'b0;
        imm_out         = imm;
        A_we            = 1'b0;
        ALU_ce          = 1'b0;
        ALU_opcode_wire = 3'b000;
        halted          = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                // The state register already sits in FETCH during reset; the
                // request is additionally qualified so memory sees no fetch
                // until reset is released.
                instr_req = rst;
            end

            S_LOAD_A: begin
                RF_addr = rs;
                A_we    = 1'b1;
            end

            S_EXEC: begin
                RF_addr         = rd;
                ALU_ce          = 1'b1;
                ALU_opcode_wire = ir_q[14:12];
            end

            S_WB: begin
                RF_addr         = rd;
                RF_we           = 1'b1;
                RF_wsel         = is_ldi;
                // Keep the ALU result stable while it is written back.
                ALU_opcode_wire = is_alu ? ir_q[14:12] : 3'b000;
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
            end
        endcase
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_simple_ctrl.sv
// -----------------------------------------------------------------------------
// tb_simple_ctrl
//
// Directed bench for simple_ctrl. Inputs change 1 ns after the rising edge and
// outputs are checked there too, well away from the next active edge. Control
// outputs are compared as one packed word:
//   {instr_req, RF_addr[1:0], RF_we, RF_wsel, A_we, ALU_ce, ALU_opcode[2:0], halted}
// -----------------------------------------------------------------------------
module tb_simple_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] instr_in;
    logic        instr_valid;
    logic        alu_zero;
    logic        instr_req;
    logic [7:0]  pc;
    logic [1:0]  RF_addr;
    logic        RF_we;
    logic        RF_wsel;
    logic [7:0]  imm_out;
    logic        A_we;
    logic        ALU_ce;
    logic [2:0]  ALU_opcode_wire;
    logic        halted;

    int n_cmp = 0;
    int n_err = 0;

    simple_ctrl #(
        .PC_W     (8),
        .RESET_PC (8'h00)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .instr_in        (instr_in),
        .instr_valid     (instr_valid),
        .alu_zero        (alu_zero),
        .instr_req       (instr_req),
        .pc              (pc),
        .RF_addr         (RF_addr),
        .RF_we           (RF_we),
        .RF_wsel         (RF_wsel),
        .imm_out         (imm_out),
        .A_we            (A_we),
        .ALU_ce          (ALU_ce),
        .ALU_opcode_wire (ALU_opcode_wire),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control word built from named fields.
    function automatic logic [15:0] ctrl(input logic req, input logic [1:0] addr,
                                         input logic we, input logic wsel,
                                         input logic awe, input logic ce,
                                         input logic [2:0] opc, input logic hlt);
        return {5'b0, req, addr, we, wsel, awe, ce, opc, hlt};
    endfunction

    function automatic logic [15:0] obs_ctrl();
        return {5'b0, instr_req, RF_addr, RF_we, RF_wsel, A_we, ALU_ce,
                ALU_opcode_wire, halted};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check_pc(input string tag, input logic [7:0] exp_pc);
        check(tag, {8'h00, pc}, {8'h00, exp_pc});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single cycle in FETCH.
    task automatic accept(input logic [15:0] word);
        instr_in    = word;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
    endtask

    // Watchdog: the directed sequence is short; anything this long is a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        rst         = 1'b0;
        instr_in    = 16'h0000;
        instr_valid = 1'b0;
        alu_zero    = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        check("rst_ctrl", obs_ctrl(), ctrl(0, 2'd0, 0, 0, 0, 0, 3'b000, 0));
        check_pc("rst_pc", 8'h00);
        check("rst_imm", {8'h00, imm_out}, 16'h0000);

        rst = 1'b1;
        #1;
        check("fetch_req_after_rst", obs_ctrl(), ctrl(1, 2'd0, 0, 0, 0, 0, 3'b000, 0));

        // ---------------- LDI r2, 5 ----------------
        accept(16'h8A05);
        check("ldi_decode", obs_ctrl(), ctrl(0, 2'd2, 0, 0, 0, 0, 3'b000, 0));
        step();
        check("ldi_wb", obs_ctrl(), ctrl(0, 2'd2, 1, 1, 0, 0, 3'b000, 0));
        check("ldi_imm", {8'h00, imm_out}, 16'h0005);
        check_pc("ldi_pc_wb", 8'h00);
        step();
        check("ldi_fetch", obs_ctrl(), ctrl(1, 2'd2, 0, 0, 0, 0, 3'b000, 0));
        check_pc("ldi_pc_next", 8'h01);

        // ---------------- ALU op 011, rd=3, rs=1 ----------------
        accept(16'h3D00);
        check("alu_decode", obs_ctrl(), ctrl(0, 2'd3, 0, 0, 0, 0, 3'b000, 0));
        step();
        check("alu_load_a", obs_ctrl(), ctrl(0, 2'd1, 0, 0, 1, 0, 3'b000, 0));
        step();
        check("alu_exec", obs_ctrl(), ctrl(0, 2'd3, 0, 0, 0, 1, 3'b011, 0));
        // Stray valid while in EXEC must not touch IR.
        instr_in    = 16'hF0F0;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        check("alu_wb", obs_ctrl(), ctrl(0, 2'd3, 1, 0, 0, 0, 3'b011, 0));
        check("stray_ir_imm", {8'h00, imm_out}, 16'h0000);
        check_pc("alu_pc_wb", 8'h01);
        step();
        check("alu_fetch", obs_ctrl(), ctrl(1, 2'd3, 0, 0, 0, 0, 3'b000, 0));
        check_pc("alu_pc_next", 8'h02);

        // ---------------- FETCH stall ----------------
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("stall_ctrl_%0d", i), obs_ctrl(), ctrl(1, 2'd3, 0, 0, 0, 0, 3'b000, 0));
            check_pc($sformatf("stall_pc_%0d", i), 8'h02);
        end

        // ---------------- ALU op with zero result, then BZ taken ----------------
        accept(16'h1600);                 // op 001, rd=1, rs=2
        step();                           // LOAD_A
        step();                           // EXEC
        check("z1_exec", obs_ctrl(), ctrl(0, 2'd1, 0, 0, 0, 1, 3'b001, 0));
        alu_zero = 1'b1;
        step();                           // WB
        alu_zero = 1'b0;
        check("z1_wb", obs_ctrl(), ctrl(0, 2'd1, 1, 0, 0, 0, 3'b001, 0));
        step();                           // FETCH
        check_pc("z1_pc", 8'h03);
        accept(16'hA040);                 // BZ 0x40
        check_pc("bz_taken_decode_pc", 8'h03);
        step();
        check_pc("bz_taken_pc", 8'h40);
        check("bz_taken_fetch", obs_ctrl(), ctrl(1, 2'd0, 0, 0, 0, 0, 3'b000, 0));

        // ---------------- ALU op with nonzero result, then BZ not taken ----------------
        accept(16'h2000);                 // op 010, rd=0, rs=0
        step();                           // LOAD_A
        step();                           // EXEC, alu_zero stays 0
        step();                           // WB
        step();                           // FETCH
        check_pc("z0_pc", 8'h41);
        accept(16'hA040);
        step();
        check_pc("bz_not_taken_pc", 8'h42);

        // ---------------- JMP 0xFF, then NOP wraps ----------------
        accept(16'h90FF);
        step();
        check_pc("jmp_pc", 8'hFF);
        accept(16'hB000);                 // unused opcode -> NOP
        check("nop_decode", obs_ctrl(), ctrl(0, 2'd0, 0, 0, 0, 0, 3'b000, 0));
        step();
        check_pc("nop_wrap_pc", 8'h00);

        // ---------------- HALT ----------------
        accept(16'hF000);                 // -> HALT on next edge
        step();
        instr_valid = 1'b1;               // requests are not honoured while halted
        instr_in    = 16'h8A05;
        for (int i = 0; i < 20; i++) begin
            check($sformatf("halt_ctrl_%0d", i), obs_ctrl(), ctrl(0, 2'd0, 0, 0, 0, 0, 3'b000, 1));
            step();
        end
        check_pc("halt_pc", 8'h00);
        instr_valid = 1'b0;

        // Reset out of HALT.
        rst = 1'b0;
        #1;
        check("halt_rst_ctrl", obs_ctrl(), ctrl(0, 2'd0, 0, 0, 0, 0, 3'b000, 0));
        step();
        rst = 1'b1;
        #1;
        check("halt_rst_fetch", obs_ctrl(), ctrl(1, 2'd0, 0, 0, 0, 0, 3'b000, 0));

        // ---------------- reset mid-EXEC ----------------
        accept(16'h9010);                 // JMP 0x10
        step();
        check_pc("pre_jmp_pc", 8'h10);
        accept(16'h3D00);
        step();                           // LOAD_A
        step();                           // EXEC
        check("mid_exec", obs_ctrl(), ctrl(0, 2'd3, 0, 0, 0, 1, 3'b011, 0));
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_ctrl", obs_ctrl(), ctrl(0, 2'd0, 0, 0, 0, 0, 3'b000, 0));
        check_pc("mid_rst_pc", 8'h00);
        step();                           // an edge while held in reset: no write-back
        check("mid_rst_hold", obs_ctrl(), ctrl(0, 2'd0, 0, 0, 0, 0, 3'b000, 0));
        rst = 1'b1;
        #1;
        check("mid_rst_fetch", obs_ctrl(), ctrl(1, 2'd0, 0, 0, 0, 0, 3'b000, 0));

        // Fetch resumes normally: LDI r3, 0x7E.
        accept(16'h8C7E);
        step();
        check("post_rst_ldi_wb", obs_ctrl(), ctrl(0, 2'd3, 1, 1, 0, 0, 3'b000, 0));
        check("post_rst_ldi_imm", {8'h00, imm_out}, 16'h007E);
        step();
        check_pc("post_rst_pc", 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
